// File: rtl/dec_38_scan.sv
// Registered 3-to-8 one-hot decoder with active-low enable, a direct-decode mode and a prescaled scan mode.
// Optional seven-segment index display is built only when DEC38_SEG_EN is defined; otherwise h stays blank.
module dec_38_scan #(
    parameter int unsigned DIV = 4,
    parameter int unsigned CW  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       dir,
    input  logic [2:0] x,
    output logic [7:0] y,
    output logic       f,
    output logic [2:0] idx,
    output logic [6:0] h
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;

    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    y_q, y_d;
    logic          f_q, f_d;
    logic          mode_q, mode_d;

    // Next-state: disable, direct decode, scan entry (re-seed from x), scan run
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        y_d    = y_q;
        f_d    = f_q;
        mode_d = mode;
        if (en) begin
            y_d    = 8'h00;
            f_d    = 1'b0;
            cnt_d  = '0;
            mode_d = 1'b0;
        end else if (!mode || !mode_q) begin
            idx_d = x;
            cnt_d = '0;
            y_d   = 8'b1 << x;
            f_d   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = dir ? (idx_q - 3'd1) : (idx_q + 3'd1);
            y_d   = 8'b1 << idx_d;
            f_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= 8'h00;
            f_q    <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            f_q    <= f_d;
            mode_q <= mode_d;
        end
    end

    assign y   = y_q;
    assign f   = f_q;
    assign idx = idx_q;

`ifdef DEC38_SEG_EN
    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] bcd7seg(input logic [2:0] v);
        case (v)
            3'd0:    bcd7seg = 7'b100_0000;
            3'd1:    bcd7seg = 7'b111_1001;
            3'd2:    bcd7seg = 7'b010_0100;
            3'd3:    bcd7seg = 7'b011_0000;
            3'd4:    bcd7seg = 7'b001_1001;
            3'd5:    bcd7seg = 7'b001_0010;
            3'd6:    bcd7seg = 7'b000_0010;
            default: bcd7seg = 7'b111_1000;
        endcase
    endfunction

    assign h = f_q ? bcd7seg(idx_q) : SEG_BLANK;
`else
    assign h = SEG_BLANK;
`endif

endmodule

// File: tb/tb_dec_38_scan.sv
// Scoreboard bench for dec_38_scan: three instances (DIV=4, 2, 1) share stimulus; each test checks one.
module tb_dec_38_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] x = 3'd0;

    logic [7:0] y4, y2, y1;
    logic       f4, f2, f1;
    logic [2:0] idx4, idx2, idx1;
    logic [6:0] h4, h2, h1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          sel;
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    dec_38_scan #(.DIV(4), .CW(16)) u_d4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .x(x),
                                          .y(y4), .f(f4), .idx(idx4), .h(h4));
    dec_38_scan #(.DIV(2), .CW(4))  u_d2 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .x(x),
                                          .y(y2), .f(f2), .idx(idx2), .h(h2));
    dec_38_scan #(.DIV(1), .CW(1))  u_d1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .x(x),
                                          .y(y1), .f(f1), .idx(idx1), .h(h1));

    function automatic logic [6:0] exp_h(input logic fv, input logic [2:0] iv);
        logic [6:0] t;
        t = 7'h7F;
`ifdef DEC38_SEG_EN
        if (fv) begin
            case (iv)
                3'd0: t = 7'h40;
                3'd1: t = 7'h79;
                3'd2: t = 7'h24;
                3'd3: t = 7'h30;
                3'd4: t = 7'h19;
                3'd5: t = 7'h12;
                3'd6: t = 7'h02;
                default: t = 7'h78;
            endcase
        end
`else
        if (fv && iv == 3'd7) t = 7'h7F;
`endif
        return t;
    endfunction

    function automatic exp_t mk(input int sel, input logic [7:0] ey, input logic ef,
                                input logic [2:0] ei, input string name);
        exp_t e;
        e.sel  = sel;
        e.v    = {ey, ef, ei, exp_h(ef, ei)};
        e.name = name;
        return e;
    endfunction

    function automatic logic [18:0] obs(input int sel);
        case (sel)
            2:       return {y2, f2, idx2, h2};
            1:       return {y1, f1, idx1, h1};
            default: return {y4, f4, idx4, h4};
        endcase
    endfunction

    function automatic logic [7:0] oh(input logic [2:0] i);
        logic [7:0] t;
        t = 8'h00;
        t[i] = 1'b1;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [18:0] o;
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; x = 3'd5;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(mk(4, 8'h00, 1'b0, 3'd0, "reset_hold"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s: got {y,f,idx,h}=%h want %h", e.name, o, e.v);
            end
        end
        rst = 1'b0;
        sb_q.push_back(mk(4, 8'h20, 1'b1, 3'd5, "reset_release"));
        tick();
        e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
        if (o !== e.v) begin
            n_errors++;
            $display("FAIL %s: got {y,f,idx,h}=%h want %h", e.name, o, e.v);
        end
    endtask

    task automatic test_direct_sweep();
        exp_t e;
        logic [18:0] o;
        for (int i = 0; i < 8; i++) begin
            en = 1'b0; mode = 1'b0; x = 3'(i);
            sb_q.push_back(mk(4, oh(3'(i)), 1'b1, 3'(i), "direct"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s x=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
        // disabled: outputs clear, idx holds, x ignored
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; x = 3'd3;
            sb_q.push_back(mk(4, 8'h00, 1'b0, 3'd7, "disable"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s: got {y,f,idx,h}=%h want %h", e.name, o, e.v);
            end
        end
    endtask

    task automatic test_scan_up_wrap();
        exp_t e;
        logic [18:0] o;
        logic [2:0] seq [10];
        seq = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
        for (int i = 0; i < 10; i++) begin
            en = 1'b0; dir = 1'b0; x = 3'd6;
            mode = (i == 0) ? 1'b0 : 1'b1;
            sb_q.push_back(mk(4, oh(seq[i]), 1'b1, seq[i], "scan_up_wrap"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s step=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
    endtask

    task automatic test_scan_down_dir();
        exp_t e;
        logic [18:0] o;
        logic [2:0] seq [9];
        seq = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0};
        for (int i = 0; i < 9; i++) begin
            en = 1'b0;
            mode = (i == 0) ? 1'b0 : 1'b1;
            x = (i < 2) ? 3'd1 : 3'd4;
            dir = (i >= 6) ? 1'b0 : 1'b1;
            sb_q.push_back(mk(2, oh(seq[i]), 1'b1, seq[i], "scan_down_dir"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s step=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
    endtask

    task automatic test_div1();
        exp_t e;
        logic [18:0] o;
        logic [2:0] seq [8];
        seq = '{3'd6, 3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd7, 3'd6};
        for (int i = 0; i < 8; i++) begin
            en = 1'b0; x = 3'd6;
            mode = (i == 0) ? 1'b0 : 1'b1;
            dir = (i >= 5) ? 1'b1 : 1'b0;
            sb_q.push_back(mk(1, oh(seq[i]), 1'b1, seq[i], "div1_step"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s step=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
    endtask

    task automatic test_en_pulse();
        exp_t e;
        logic [18:0] o;
        // direct 3, entry 3, hold 3, en pulse (x=2), re-entry 2, hold x3, step to 3
        logic [2:0] si [9];
        logic       sf [9];
        si = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        sf = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            dir = 1'b0;
            mode = (i == 0) ? 1'b0 : 1'b1;
            en = (i == 3) ? 1'b1 : 1'b0;
            x = (i < 3) ? 3'd3 : 3'd2;
            sb_q.push_back(mk(4, sf[i] ? oh(si[i]) : 8'h00, sf[i], si[i], "en_pulse"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s step=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
    endtask

    task automatic test_rst_mid_scan();
        exp_t e;
        logic [18:0] o;
        logic [2:0] si [6];
        logic       sf [6];
        si = '{3'd0, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6};
        sf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            en = 1'b0; mode = 1'b1; dir = 1'b0; x = 3'd5;
            rst = (i == 0) ? 1'b1 : 1'b0;
            sb_q.push_back(mk(4, sf[i] ? oh(si[i]) : 8'h00, sf[i], si[i], "rst_mid_scan"));
            tick();
            e = sb_q.pop_front(); o = obs(e.sel); n_checks++;
            if (o !== e.v) begin
                n_errors++;
                $display("FAIL %s step=%0d: got {y,f,idx,h}=%h want %h", e.name, i, o, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct_sweep();
        test_scan_up_wrap();
        test_scan_down_dir();
        test_div1();
        test_en_pulse();
        test_rst_mid_scan();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dec_38_scan.md
# dec_38_scan

Registered 3-to-8 one-hot decoder with active-low enable, the decode-side counterpart to the lab's 8-to-3 priority encoder. In direct mode it decodes a 3-bit code onto 8 outputs. In scan mode it walks the active output through all eight positions at a programmable rate. The current index is shown on one seven-segment digit. The block sits between board switches/encoder outputs and the LED/digit bank.

## Interface
Parameters:
- DIV, default 4, prescaler period in clocks per scan step; legal range 1..2^16.
- CW, default 16, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable, active-low (0 = decoder active, 1 = forced idle).
- mode  input  1  0 = direct decode of x; 1 = scan.
- dir  input  1  scan direction: 0 = up (idx+1), 1 = down (idx-1).
- x  input  3  code to decode in direct mode; seed index on scan entry.
- y  output  8  registered one-hot output; y[idx] = 1 when active.
- f  output  1  registered valid flag: 1 when y is non-zero.
- idx  output  3  registered current index.
- h  output  7  active-low seven-segment pattern of idx, from the team's bcd7seg mapping.

## Operation
- Internal state: idx[2:0], prescaler cnt[CW-1:0], registered mode_q (mode from the previous cycle), y, f.
- Reset (rst=1 at a rising edge) sets y=8'h00, f=0, idx=0, cnt=0, mode_q=0. rst overrides every other input.
- Disabled state (en=1): y=8'h00 and f=0 from the next edge. cnt is cleared. idx holds its value.
- Direct mode (en=0, mode=0): idx<=x, y<=8'b1<<x, f<=1. cnt is held at 0.
- Scan entry (en=0, mode=1, mode_q=0): idx<=x, cnt<=0, y<=8'b1<<x, f<=1.
- Scan run (en=0, mode=1, mode_q=1):
  - When cnt==DIV-1: cnt<=0, and idx steps by ±1 according to dir. The step wraps modulo 8 (7->0 up, 0->7 down). y follows the new idx on the same edge.
  - Otherwise: cnt<=cnt+1, and idx and y hold.
- Index arithmetic is 3-bit unsigned; wrap-around is inherent.
- When en goes from 1 to 0 with mode=1, it is treated as scan entry: idx reloads from x.
- dir may change at any cycle. It takes effect at the next step edge only.
- mode_q updates every cycle. It is cleared whenever en=1, so that re-enabling always re-seeds idx.

## Timing
- Direct mode latency: x to y/idx/f is 1 clock.
- Scan step period: exactly DIV clocks.
  - The first step occurs DIV clocks after the scan-entry edge.
  - DIV=1 steps every clock.
- h is combinational from the idx and f registers, so it is valid in the same cycle as idx.
- Enable/disable latency: 1 clock.
- Reset latency: 1 clock. A reset asserted mid-scan aborts the scan. After reset is released, the first edge behaves as scan entry if mode=1 and en=0.

## Configuration
- DEC38_SEG_EN defined:
  - h = bcd7seg pattern of idx when f=1.
  - h = 7'b111_1111 (blank) when f=0, including during and after reset.
- DEC38_SEG_EN undefined:
  - h is tied to 7'b111_1111 permanently.
  - No seven-segment logic is instantiated.
  - All other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 clocks with en=0, mode=0, x=5 -> y=8'h00, f=0, idx=0, h blank. One clock after rst drops -> y=8'h20, f=1, idx=5.
- Direct sweep: en=0, mode=0, x=0..7 on successive clocks -> y = 8'h01, 02, 04, ..., 80, each one clock after x. en=1 -> y=8'h00, f=0 next clock.
- Scan up with wrap: DIV=4, x=6, mode 0->1, dir=0 -> idx stays 6 for 4 clocks, then 7 for 4 clocks, then 0 (y=8'h01).
- Scan down with direction change: DIV=2, x=1, dir=1 -> idx sequence 1,1,0,0,7,7. Set dir=0 while idx=7 -> next step gives 0.
- Mid-scan disruptions:
  - en pulses to 1 for 1 clock during a scan at idx=3, with x=2 -> y=8'h00, f=0 for that clock; on re-enable, idx reloads to 2 and cnt restarts.
  - rst during scan -> idx=0, y=0.
- Config: build with DEC38_SEG_EN undefined -> h=7'h7F throughout the direct and scan tests. Build with it defined -> h matches bcd7seg(idx) whenever f=1.
